pc_fetch_unit: RTL
==================

# pc_fetch_unit

Fetch-stage program-counter unit sitting directly downstream of the branch control unit. It consumes the taken-branch decision (`Anded`), the jump indication and the resolved target. It drives a req/ack instruction-memory handshake, presents the fetched instruction and its PC to decode, and flushes the younger instruction on redirect. A one-entry skid buffer absorbs a memory response that arrives while decode is stalled.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INST`, 32'h0000_0013, instruction shown on `inst_out` at reset and after flush (addi x0,x0,0).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low (0 = reset).
- `branch_taken` in 1: branch control unit `Anded` output.
- `jump` in 1: jal/jalr resolved this cycle.
- `target_addr` in 32: branch/jump target; valid when `branch_taken|jump`.
- `stall` in 1: hazard unit request to hold decode.
- `imem_req` out 1: instruction-memory request.
- `imem_addr` out 32: request address.
- `imem_ack` in 1: response valid; may assert in the same cycle as `imem_req`.
- `imem_rdata` in 32: instruction word, valid with `imem_ack`.
- `inst_out` out 32: instruction to decode.
- `pc_out` out 32: PC of `inst_out`.
- `inst_valid` out 1: `inst_out` is a real instruction.
- `flush` out 1: one-cycle pulse; decode/execute kill younger instruction.
- `misaligned` out 1: one-cycle pulse; `target_addr[1:0]` was nonzero on redirect.

## Operation
- Redirect = `branch_taken | jump`. It has priority over `stall` and over a same-cycle `imem_ack`.
- Redirect effects are registered:
  - `pc_q` <= `{target_addr[31:2],2'b00}`.
  - `flush` = 1 and `inst_valid` = 0 for the next cycle.
  - `misaligned` = `|target_addr[1:0]` for that cycle.
- States are IDLE, REQ, HOLD and DROP.
- IDLE: entered only from reset. `imem_req` = 0 and `imem_ack` is ignored. Next state is REQ.
- REQ: `imem_req` = 1, `imem_addr` = `pc_q`. Once raised, req and addr stay stable until ack.
  - ack, no redirect, no stall: `inst_out` <= rdata, `pc_out` <= `pc_q`, `inst_valid` <= 1, `pc_q` <= `pc_q`+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0). Stay in REQ.
  - ack, no redirect, stall: `skid` <= rdata, `skid_pc` <= `pc_q`, `pc_q` += 4. `inst_out`, `pc_out` and `inst_valid` hold. Go to HOLD.
  - ack with redirect: discard the word. Stay in REQ at the new `pc_q`.
  - no ack, no redirect: stay in REQ. `inst_valid` <= 0 if stall = 0, else it holds.
  - no ack, redirect: `old_addr_q` <= `pc_q`. Go to DROP.
- HOLD: `imem_req` = 0.
  - stall = 0: `inst_out` <= skid, `pc_out` <= `skid_pc`, `inst_valid` <= 1. Go to REQ.
  - redirect: skid is discarded. Go to REQ.
- DROP: `imem_req` = 1, `imem_addr` = `old_addr_q`. This completes the abandoned transaction.
  - ack: discard the word. Go to REQ.
  - A further redirect updates `pc_q` only (the latest target wins) and pulses `flush` again.
- `inst_valid` = 0 outside an accepted, non-flushed word.

## Timing
- Reset values:
  - state IDLE, `pc_q` = `RESET_PC`.
  - `imem_req` = 0, `imem_addr` = `RESET_PC`.
  - `inst_out` = `NOP_INST`, `pc_out` = `RESET_PC`.
  - `inst_valid` = 0, `flush` = 0, `misaligned` = 0.
  - `skid` = `NOP_INST`, `old_addr_q` = `RESET_PC`.
- Reset mid-transaction aborts immediately. A late ack after release is ignored in IDLE.
- Zero-wait memory (ack same cycle as req):
  - first `imem_req` in cycle 1 after `rst` rises;
  - first `inst_valid` in cycle 2;
  - then 1 instruction per cycle.
- Redirect to first new-target `inst_valid`:
  - 2 cycles with zero-wait memory;
  - +N cycles of old-transaction latency if the redirect lands in DROP.
- All outputs are registered except `imem_req`/`imem_addr`, which decode from state and registers.

## Test plan
- Reset release, zero-wait memory: `pc_out` sequence 0x0, 0x4, 0x8 with `inst_valid` = 1 from cycle 2; `imem_addr` increments by 4 each cycle.
- `branch_taken` = 1, `target_addr` = 0x100 at `pc_q` = 0x10 with same-cycle ack: word discarded, `flush` = 1 for one cycle, next `imem_addr` = 0x100, next valid `pc_out` = 0x100.
- Memory with 3-cycle ack latency, `jump` = 1 (target 0x200) one cycle after req: `imem_addr` holds the old address until ack, that word is discarded, then `imem_addr` = 0x200.
- `stall` = 1 when ack returns word 0xDEADBEEF: `inst_out` unchanged, `imem_req` = 0 while stalled; on stall release `inst_out` = 0xDEADBEEF with its PC; no word lost or duplicated.
- `target_addr` = 0x102 on redirect: `misaligned` pulses one cycle, fetch resumes at 0x100. `pc_q` = 0xFFFF_FFFC accepted: next `imem_addr` = 0x0.
- `rst` asserted while in DROP with ack pending: outputs return to reset values asynchronously; ack in the first post-reset cycle is ignored; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC unit: imem req/ack handshake, redirect flush,
// and a one-entry skid buffer for responses arriving under stall.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic [31:0] target_addr,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        inst_valid,
  output logic        flush,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DROP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] old_addr_q, old_addr_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic        flush_q, flush_d;
  logic        mis_q, mis_d;

  logic        redirect;
  logic [31:0] tgt_aligned;
  logic [31:0] pc_inc;

  assign redirect    = branch_taken | jump;
  assign tgt_aligned = {target_addr[31:2], 2'b00};
  assign pc_inc      = pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    old_addr_d = old_addr_q;
    skid_d     = skid_q;
    skid_pc_d  = skid_pc_q;
    inst_d     = inst_q;
    pc_out_d   = pc_out_q;
    valid_d    = valid_q;
    flush_d    = 1'b0;
    mis_d      = 1'b0;

    // Redirect wins over stall and over any same-cycle response.
    if (redirect) begin
      pc_d    = tgt_aligned;
      flush_d = 1'b1;
      mis_d   = |target_addr[1:0];
      valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        unique case (1'b1)
          redirect && !imem_ack: begin
            old_addr_d = pc_q;
            state_d    = DROP;
          end
          redirect && imem_ack: begin
            state_d = REQ;
          end
          !redirect && imem_ack && stall: begin
            skid_d    = imem_rdata;
            skid_pc_d = pc_q;
            pc_d      = pc_inc;
            state_d   = HOLD;
          end
          !redirect && imem_ack && !stall: begin
            inst_d   = imem_rdata;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_inc;
          end
          default: begin
            if (!stall) valid_d = 1'b0;
          end
        endcase
      end
      HOLD: begin
        if (redirect) begin
          state_d = REQ;
        end else if (!stall) begin
          inst_d   = skid_q;
          pc_out_d = skid_pc_q;
          valid_d  = 1'b1;
          state_d  = REQ;
        end
      end
      DROP: begin
        // The abandoned word is never presented.
        valid_d = 1'b0;
        if (imem_ack) state_d = REQ;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      old_addr_q <= RESET_PC;
      skid_q     <= NOP_INST;
      skid_pc_q  <= RESET_PC;
      inst_q     <= NOP_INST;
      pc_out_q   <= RESET_PC;
      valid_q    <= 1'b0;
      flush_q    <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      old_addr_q <= old_addr_d;
      skid_q     <= skid_d;
      skid_pc_q  <= skid_pc_d;
      inst_q     <= inst_d;
      pc_out_q   <= pc_out_d;
      valid_q    <= valid_d;
      flush_q    <= flush_d;
      mis_q      <= mis_d;
    end
  end

  assign imem_req   = (state_q == REQ) || (state_q == DROP);
  assign imem_addr  = (state_q == DROP) ? old_addr_q : pc_q;
  assign inst_out   = inst_q;
  assign pc_out     = pc_out_q;
  assign inst_valid = valid_q;
  assign flush      = flush_q;
  assign misaligned = mis_q;

endmodule
